// File: rtl/swap_count_ctrl.sv
// Two-requester job controller driving a counter pair: N enable cycles, optional swap cycle, ack.
// Define SWAP_CTRL_RR_ARB_EN for round-robin tie-break; otherwise requester 0 wins ties.
module swap_count_ctrl (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic [3:0] steps0,
  input  logic [3:0] steps1,
  input  logic [1:0] swap_req,
  output logic       enable,
  output logic       swap,
  output logic [1:0] grant,
  output logic [1:0] ack,
  output logic       busy,
  output logic [3:0] steps_left
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_SWAP  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       swap_flag_q, swap_flag_d;
  logic [3:0] steps_left_q, steps_left_d;
  logic       win;
  logic [3:0] win_steps;
  logic       win_swap;

`ifdef SWAP_CTRL_RR_ARB_EN
  logic last_q, last_d;

  // On a tie, serve whoever was not served last.
  always_comb begin
    if (req == 2'b11) win = ~last_q;
    else              win = req[1];
  end
`else
  always_comb win = ~req[0];
`endif

  always_comb begin
    win_steps = win ? steps1 : steps0;
    win_swap  = swap_req[win];
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    swap_flag_d  = swap_flag_q;
    steps_left_d = steps_left_q;
`ifdef SWAP_CTRL_RR_ARB_EN
    last_d       = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          owner_d      = win;
          swap_flag_d  = win_swap;
          steps_left_d = win_steps;
`ifdef SWAP_CTRL_RR_ARB_EN
          last_d       = win;
`endif
          if (win_steps != 4'd0) state_d = S_COUNT;
          else if (win_swap)     state_d = S_SWAP;
          else                   state_d = S_DONE;
        end
      end
      S_COUNT: begin
        // Guard keeps the counter from wrapping even if entered with zero.
        if (steps_left_q != 4'd0) steps_left_d = steps_left_q - 4'd1;
        if (steps_left_q <= 4'd1) state_d = swap_flag_q ? S_SWAP : S_DONE;
      end
      S_SWAP:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      swap_flag_q  <= 1'b0;
      steps_left_q <= 4'd0;
`ifdef SWAP_CTRL_RR_ARB_EN
      last_q       <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      swap_flag_q  <= swap_flag_d;
      steps_left_q <= steps_left_d;
`ifdef SWAP_CTRL_RR_ARB_EN
      last_q       <= last_d;
`endif
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign enable     = (state_q == S_COUNT) || (state_q == S_SWAP);
  assign swap       = (state_q == S_SWAP);
  assign grant      = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign ack        = (state_q == S_DONE) ? grant : 2'b00;
  assign steps_left = steps_left_q;

endmodule

// File: tb/tb_swap_count_ctrl.sv
// Randomized bench for swap_count_ctrl: each accepted job is expanded into its full
// per-cycle output sequence and compared every cycle, plus literal scenario checks.
module tb_swap_count_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] req;
  logic [3:0] steps0, steps1;
  logic [1:0] swap_req;
  logic       enable, swap, busy;
  logic [1:0] grant, ack;
  logic [3:0] steps_left;

  swap_count_ctrl dut (
    .clock(clock), .reset_n(reset_n), .req(req), .steps0(steps0), .steps1(steps1),
    .swap_req(swap_req), .enable(enable), .swap(swap), .grant(grant), .ack(ack),
    .busy(busy), .steps_left(steps_left)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       en;
    logic       sw;
    logic [3:0] sl;
    logic [1:0] gnt;
    logic [1:0] ak;
    logic       bsy;
  } exp_t;

  localparam exp_t IDLE_EXP = '0;

  exp_t cur;
  exp_t jobq[$];
  logic last_served;
  int   vecs = 0;
  int   miss = 0;

  task automatic chk(input string name, input int act, input int expv);
    vecs++;
    if (act != expv) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic compare();
    chk("enable", int'(enable), int'(cur.en));
    chk("swap", int'(swap), int'(cur.sw));
    chk("steps_left", int'(steps_left), int'(cur.sl));
    chk("grant", int'(grant), int'(cur.gnt));
    chk("ack", int'(ack), int'(cur.ak));
    chk("busy", int'(busy), int'(cur.bsy));
  endtask

  // Advance the reference by one clock, using the inputs about to be sampled.
  task automatic model_advance();
    int   w, n;
    logic sf;
    logic [1:0] g;
    exp_t e;
    if (jobq.size() != 0) begin
      cur = jobq.pop_front();
    end else if (cur.bsy) begin
      cur = IDLE_EXP;
    end else if (req != 2'b00) begin
      if (req == 2'b01) w = 0;
      else if (req == 2'b10) w = 1;
      else begin
`ifdef SWAP_CTRL_RR_ARB_EN
        w = last_served ? 0 : 1;
`else
        w = 0;
`endif
      end
      last_served = (w == 1);
      n  = (w == 1) ? int'(steps1) : int'(steps0);
      sf = swap_req[w];
      g  = (w == 1) ? 2'b10 : 2'b01;
      for (int k = 0; k < n; k++) begin
        e = '{en: 1'b1, sw: 1'b0, sl: 4'(n - k), gnt: g, ak: 2'b00, bsy: 1'b1};
        jobq.push_back(e);
      end
      if (sf) begin
        e = '{en: 1'b1, sw: 1'b1, sl: 4'd0, gnt: g, ak: 2'b00, bsy: 1'b1};
        jobq.push_back(e);
      end
      e = '{en: 1'b0, sw: 1'b0, sl: 4'd0, gnt: g, ak: g, bsy: 1'b1};
      jobq.push_back(e);
      cur = jobq.pop_front();
    end
  endtask

  task automatic cyc(input logic [1:0] r, input logic [3:0] s0, input logic [3:0] s1,
                     input logic [1:0] sr);
    req = r; steps0 = s0; steps1 = s1; swap_req = sr;
    model_advance();
    @(negedge clock);
    compare();
  endtask

  // Asynchronous reset asserted away from the clock edge; outputs must clear at once.
  task automatic do_reset();
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    jobq.delete();
    cur = IDLE_EXP;
    last_served = 1'b1;
    compare();
    @(negedge clock);
    compare();
    reset_n = 1'b1;
  endtask

  int cnt;
  int gexp;

  initial begin
    reset_n = 1'b0; req = 2'b00; steps0 = 4'd0; steps1 = 4'd0; swap_req = 2'b00;
    cur = IDLE_EXP; last_served = 1'b1;
    repeat (3) @(negedge clock);
    compare();
    chk("reset_busy", int'(busy), 0);
    chk("reset_grant", int'(grant), 0);
    reset_n = 1'b1;

    // Plain 3-step job for requester 0.
    cyc(2'b01, 4'd3, 4'd0, 2'b00);
    chk("j1_grant", int'(grant), 1);
    chk("j1_sl3", int'(steps_left), 3);
    cyc(2'b01, 4'd3, 4'd0, 2'b00);
    chk("j1_sl2", int'(steps_left), 2);
    cyc(2'b01, 4'd3, 4'd0, 2'b00);
    chk("j1_sl1", int'(steps_left), 1);
    cyc(2'b01, 4'd3, 4'd0, 2'b00);
    chk("j1_ack", int'(ack), 1);
    chk("j1_en_done", int'(enable), 0);
    cyc(2'b00, 4'd3, 4'd0, 2'b00);
    chk("j1_idle", int'(busy), 0);

    // Requester 1, two steps plus swap.
    cyc(2'b10, 4'd9, 4'd2, 2'b10);
    chk("j2_en", int'(enable), 1);
    chk("j2_sw0", int'(swap), 0);
    cyc(2'b10, 4'd9, 4'd2, 2'b10);
    chk("j2_sw1", int'(swap), 0);
    cyc(2'b10, 4'd9, 4'd2, 2'b10);
    chk("j2_swap", int'({enable, swap}), 3);
    cyc(2'b10, 4'd9, 4'd2, 2'b10);
    chk("j2_ack", int'(ack), 2);
    cyc(2'b00, 4'd0, 4'd0, 2'b00);

    // Zero steps with swap: a single enable+swap cycle.
    cyc(2'b01, 4'd0, 4'd0, 2'b01);
    chk("j3_swap", int'({enable, swap}), 3);
    chk("j3_grant", int'(grant), 1);
    cyc(2'b01, 4'd0, 4'd0, 2'b01);
    chk("j3_ack", int'(ack), 1);
    chk("j3_en", int'(enable), 0);
    cyc(2'b00, 4'd0, 4'd0, 2'b00);

    // Held tie: alternating grants under round-robin, constant 01 otherwise.
    do_reset();
    for (int j = 0; j < 3; j++) begin
      cyc(2'b11, 4'd1, 4'd1, 2'b00);
`ifdef SWAP_CTRL_RR_ARB_EN
      gexp = (j % 2 == 0) ? 1 : 2;
`else
      gexp = 1;
`endif
      chk("tie_grant", int'(grant), gexp);
      cyc(2'b11, 4'd1, 4'd1, 2'b00);
      cyc(2'b11, 4'd1, 4'd1, 2'b00);
    end
    cyc(2'b00, 4'd0, 4'd0, 2'b00);

    // Reset mid-count, then a full restart of the held request.
    cyc(2'b01, 4'd7, 4'd0, 2'b00);
    cyc(2'b01, 4'd7, 4'd0, 2'b00);
    cyc(2'b01, 4'd7, 4'd0, 2'b00);
    chk("abort_sl5", int'(steps_left), 5);
    do_reset();
    chk("abort_all0", int'({enable, swap, grant, ack, busy, steps_left}), 0);
    cyc(2'b01, 4'd7, 4'd0, 2'b00);
    chk("restart_sl7", int'(steps_left), 7);
    while (busy) cyc(2'b00, 4'd0, 4'd0, 2'b00);
    cyc(2'b00, 4'd0, 4'd0, 2'b00);

    // Maximum length job.
    cnt = 0;
    cyc(2'b01, 4'd15, 4'd0, 2'b00);
    while (cnt < 20 && enable) begin
      cnt++;
      chk("max_no_swap", int'(swap), 0);
      cyc(2'b01, 4'd15, 4'd0, 2'b00);
    end
    chk("max_en_cycles", cnt, 15);
    chk("max_sl0", int'(steps_left), 0);
    chk("max_ack", int'(ack), 1);
    cyc(2'b00, 4'd0, 4'd0, 2'b00);

    // Random traffic with occasional async resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      cyc(2'($urandom_range(0, 3)),
          ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
          ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 6)),
          2'($urandom_range(0, 3)));
      if (enable && swap && !(cur.sw)) chk("en_sw_overlap", 1, 0);
      if (grant == 2'b11) chk("grant_11", int'(grant), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/swap_count_ctrl.md
SWAP_COUNT_CTRL -- requirements
Module: swap_count_ctrl

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  2  per-requester job request; held high until the matching ack.
REQ-005 steps0  input  4  requester 0 count-cycle count, sampled at grant.
REQ-006 steps1  input  4  requester 1 count-cycle count, sampled at grant.
REQ-007 swap_req  input  2  per-requester flag: append a swap cycle after counting; sampled at grant.
REQ-008 enable  output  1  drives the counter-pair enable.
REQ-009 swap  output  1  drives the counter-pair swap.
REQ-010 grant  output  2  one-hot owner of the current job; 2'b00 when idle.
REQ-011 ack  output  2  one-cycle completion pulse to the owner.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 steps_left  output  4  remaining count cycles of the current job.

Function
REQ-014 FSM states SHALL be IDLE, COUNT, SWAP, DONE; all outputs are Moore, decoded from registered state only.
REQ-015 IDLE: enable=0, swap=0, grant=0, ack=0; req SHALL be sampled only in IDLE.
REQ-016 IDLE with req!=0: latch winner index, its steps value into steps_left and its swap_req bit; grant=winner one-hot from the next cycle.
REQ-017 IDLE exit: latched steps!=0 -> COUNT; steps==0 and swap flag -> SWAP; steps==0 and no swap flag -> DONE.
REQ-018 COUNT: enable=1, swap=0; steps_left decrements by 1 each cycle; exactly N enable cycles for steps=N (1..15).
REQ-019 COUNT exit when steps_left==1: swap flag set -> SWAP, else -> DONE; steps_left SHALL read 0 on exit and never wrap.
REQ-020 SWAP: enable=1, swap=1 for exactly one cycle, then DONE.
REQ-021 DONE: ack[owner]=1 for one cycle, grant held, enable=0, then IDLE with grant cleared.
REQ-022 Latency: req rising in IDLE -> first enable cycle 1 clock later; job length = 1 + N + (swap?1:0) + 1 cycles including DONE.
REQ-023 req changes and steps/swap_req changes while busy SHALL be ignored; the latched job runs to completion.
REQ-024 A req still high in the IDLE cycle following ack SHALL be treated as a new request.
REQ-025 enable and swap SHALL never both be high outside SWAP; grant SHALL never be 2'b11.

Reset
REQ-026 reset_n low SHALL immediately force IDLE, steps_left=0, grant=0, ack=0, enable=0, swap=0, busy=0, and round-robin pointer = last-served 1.
REQ-027 Reset asserted mid-job SHALL abort it with no ack; after release the requester re-arbitrates from IDLE.

Configuration
REQ-028 Macro SWAP_CTRL_RR_ARB_EN defined: round-robin arbitration; with both req high, grant goes to the requester not served last; the pointer updates at grant.
REQ-029 SWAP_CTRL_RR_ARB_EN undefined: fixed priority, requester 0 always wins a tie; pointer logic absent.

Verification
REQ-030 Reset release, req=2'b01, steps0=3, swap_req=0 -> grant=01 next cycle; enable high 3 cycles with steps_left 3,2,1; ack=01 one cycle; busy low after.
REQ-031 req=2'b10, steps1=2, swap_req[1]=1 -> enable 2 cycles with swap=0, then 1 cycle enable=1 and swap=1, then ack=10.
REQ-032 req=2'b01, steps0=0, swap_req[0]=1 -> IDLE->SWAP->DONE; exactly one enable pulse, with swap=1.
REQ-033 req=2'b11 held, steps0=1, steps1=1: with SWAP_CTRL_RR_ARB_EN grants alternate 01,10,01; without it grant stays 01 every job.
REQ-034 reset_n low during COUNT with steps_left=5 -> all outputs 0 asynchronously; no ack; after release, held req=01 restarts a full job.
REQ-035 steps0=15 -> exactly 15 enable cycles; steps_left reaches 0 without wrap; enable/swap never both high in COUNT.
